// File: rtl/mips_tb_pkg.sv
// Shared types and MISR constants for the CPU reset sequencer harness.
package mips_tb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        RUN   = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

    localparam int unsigned FOLD_MAX_W = 64;
    localparam int unsigned FOLD_IDX_W = $clog2(FOLD_MAX_W);

    // Rotate the low w bits of x left by r; channels wider than FOLD_MAX_W are not supported.
    function automatic logic [FOLD_MAX_W-1:0] fold_rotl(input logic [FOLD_MAX_W-1:0] x,
                                                         input int unsigned w,
                                                         input int unsigned r);
        logic [FOLD_MAX_W-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < FOLD_MAX_W; i++) begin
            if (i < w) begin
                y[FOLD_IDX_W'((i + r) % w)] = x[FOLD_IDX_W'(i)];
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/misr_accum.sv
// Multiple-input signature register: rotate, conditional polynomial XOR, data XOR.
module misr_accum #(
    parameter int unsigned      SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = '0,
    parameter logic [SIG_W-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [SIG_W-1:0] data_i,
    output logic [SIG_W-1:0] sig_o,
    output logic [SIG_W-1:0] sig_nxt_c
);

    always_comb begin
        sig_nxt_c = sig_o;
        if (clear_i) begin
            sig_nxt_c = SEED;
        end else if (enable_i) begin
            sig_nxt_c = {sig_o[SIG_W-2:0], sig_o[SIG_W-1]}
                      ^ (sig_o[SIG_W-1] ? POLY : '0)
                      ^ data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_o <= SEED;
        end else begin
            sig_o <= sig_nxt_c;
        end
    end

endmodule

// File: rtl/cpu_reset_sequencer.sv
// Multi-pulse CPU reset sequencer with MISR signing of observed buses in the final window.
// Optional stall watchdog on channel 0 enabled by defining WATCHDOG_EN.
module cpu_reset_sequencer
    import mips_tb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned SIG_W      = 32,
    parameter int unsigned NUM_RESETS = 2,
    parameter int unsigned RST0_CYC   = 10,
    parameter int unsigned RSTN_CYC   = 1,
    parameter int unsigned RUN_CYC    = 10,
    parameter int unsigned FINAL_CYC  = 100,
    parameter int unsigned STALL_CYC  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [NUM_CH*DATA_W-1:0] obs_i,
    input  logic [SIG_W-1:0]         expect_sig_i,
    output logic                     dut_rst_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic [SIG_W-1:0]         sig_o,
    output logic [7:0]               pulse_cnt_o,
    output logic                     stall_o
);

    localparam int unsigned MAX_A   = (RST0_CYC > RSTN_CYC) ? RST0_CYC : RSTN_CYC;
    localparam int unsigned MAX_B   = (RUN_CYC > FINAL_CYC) ? RUN_CYC : FINAL_CYC;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYC = (MAX_AB > STALL_CYC) ? MAX_AB : STALL_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         pulse_d;
    logic               stall_d;
    logic               pass_d;
    logic               misr_clr_c;
    logic               misr_en_c;
    logic               stall_hit_c;
    logic [SIG_W-1:0]   fold_c;
    logic [SIG_W-1:0]   sig_nxt_c;

    // Channel c contributes its value rotated left by c.
    always_comb begin
        fold_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            fold_c = fold_c ^ SIG_W'(fold_rotl(FOLD_MAX_W'(DATA_W'(obs_i >> (c * DATA_W))),
                                               DATA_W, c));
        end
    end

`ifdef WATCHDOG_EN
    localparam int unsigned SCNT_W = $clog2(STALL_CYC + 1);

    logic [DATA_W-1:0] ch0_prev_q;
    logic [SCNT_W-1:0] scnt_q, scnt_d;

    always_comb begin
        scnt_d = '0;
        if (state_q == FINAL && obs_i[DATA_W-1:0] == ch0_prev_q) begin
            scnt_d = scnt_q + SCNT_W'(1);
        end
    end

    assign stall_hit_c = (state_q == FINAL) && (scnt_d == SCNT_W'(STALL_CYC));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch0_prev_q <= '0;
            scnt_q     <= '0;
        end else begin
            ch0_prev_q <= obs_i[DATA_W-1:0];
            scnt_q     <= scnt_d;
        end
    end
`else
    assign stall_hit_c = 1'b0;
`endif

    // Next-state, counter loads and MISR control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_d    = pulse_cnt_o;
        stall_d    = stall_o;
        pass_d     = 1'b0;
        misr_clr_c = 1'b0;
        misr_en_c  = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            pulse_d = '0;
            stall_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_d    = HOLD;
                        cnt_d      = CNT_W'(RST0_CYC - 1);
                        pulse_d    = 8'd1;
                        stall_d    = 1'b0;
                        misr_clr_c = 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        if (pulse_cnt_o < 8'(NUM_RESETS)) begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(RUN_CYC - 1);
                        end else begin
                            state_d    = FINAL;
                            cnt_d      = CNT_W'(FINAL_CYC - 1);
                            misr_clr_c = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(RSTN_CYC - 1);
                        pulse_d = pulse_cnt_o + 8'd1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FINAL: begin
                    misr_en_c = 1'b1;
                    if (cnt_q == '0 || stall_hit_c) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        stall_d = stall_hit_c;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pulse_d = '0;
                end
            endcase
        end

        // Verdict uses the signature including the last FINAL sample.
        if (state_d == DONE) begin
            pass_d = (state_q == DONE) ? pass_o : (!stall_hit_c && sig_nxt_c == expect_sig_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse_cnt_o <= '0;
            stall_o     <= 1'b0;
            pass_o      <= 1'b0;
            dut_rst_o   <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_cnt_o <= pulse_d;
            stall_o     <= stall_d;
            pass_o      <= pass_d;
            dut_rst_o   <= (state_d == IDLE) || (state_d == HOLD);
            busy_o      <= (state_d == HOLD) || (state_d == RUN) || (state_d == FINAL);
            done_o      <= (state_d == DONE);
        end
    end

    misr_accum #(
        .SIG_W (SIG_W),
        .POLY  (SIG_W'(MISR_POLY)),
        .SEED  (SIG_W'(MISR_SEED))
    ) u_misr (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (misr_clr_c),
        .enable_i  (misr_en_c),
        .data_i    (fold_c),
        .sig_o     (sig_o),
        .sig_nxt_c (sig_nxt_c)
    );

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Scoreboard bench: default sequencer (dut 0) and a four-pulse variant (dut 1).
module tb_cpu_reset_sequencer;

    typedef struct {
        logic [31:0] sig;
        logic        pass;
        logic [7:0]  pulse;
        int          busy_len;
        int          n_holds;
        int          holds [4];
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [95:0] obs;
    logic        obs_mode = 1'b0;
    int          cyc = 0;

    logic        start_w  [2];
    logic        abort_w  [2];
    logic [31:0] expect_w [2];
    logic        dut_rst_w[2];
    logic        busy_w   [2];
    logic        done_w   [2];
    logic        pass_w   [2];
    logic [31:0] sig_w    [2];
    logic [7:0]  pulse_w  [2];
    logic        stall_w  [2];

    int chk = 0;
    int err = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [95:0] pattern(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {kk ^ 32'hA5A5_0F0F, {kk[15:0], ~kk[15:0]}, kk * 32'h9E37_79B9};
    endfunction

    assign obs = obs_mode ? pattern(cyc) : 96'd0;

    cpu_reset_sequencer u_dut (
        .clk(clk), .rst(rst), .start_i(start_w[0]), .abort_i(abort_w[0]), .obs_i(obs),
        .expect_sig_i(expect_w[0]), .dut_rst_o(dut_rst_w[0]), .busy_o(busy_w[0]),
        .done_o(done_w[0]), .pass_o(pass_w[0]), .sig_o(sig_w[0]), .pulse_cnt_o(pulse_w[0]),
        .stall_o(stall_w[0])
    );

    cpu_reset_sequencer #(.NUM_RESETS(4), .RSTN_CYC(3)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start_w[1]), .abort_i(abort_w[1]), .obs_i(obs),
        .expect_sig_i(expect_w[1]), .dut_rst_o(dut_rst_w[1]), .busy_o(busy_w[1]),
        .done_o(done_w[1]), .pass_o(pass_w[1]), .sig_o(sig_w[1]), .pulse_cnt_o(pulse_w[1]),
        .stall_o(stall_w[1])
    );

    function automatic logic [31:0] fold_m(input logic [95:0] o);
        return o[31:0] ^ {o[62:32], o[63]} ^ {o[93:64], o[95:94]};
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
        logic [31:0] n;
        n = (s << 1) | {31'd0, s[31]};
        if (s[31]) n = n ^ 32'h04C1_1DB7;
        return n ^ f;
    endfunction

    // Signature after 100 FINAL samples; sample i sees the pattern for cycle p+21+i.
    function automatic logic [31:0] model(input logic mode, input int p);
        logic [31:0] s;
        s = 32'hFFFF_FFFF;
        for (int i = 0; i < 100; i++) begin
            s = misr_step(s, mode ? fold_m(pattern(p + 21 + i)) : 32'd0);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk++;
        if (act !== req) begin
            err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int d, input logic [31:0] sig, input logic pass,
                            input int nres, input int rstn, input int blen);
        exp_t e;
        e.sig      = sig;
        e.pass     = pass;
        e.pulse    = 8'(nres);
        e.busy_len = blen;
        e.n_holds  = nres;
        e.holds[0] = 10;
        for (int i = 1; i < 4; i++) e.holds[i] = rstn;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic do_start(input int d, output int p);
        @(negedge clk);
        start_w[d] = 1'b1;
        p = cyc + 1;
        @(negedge clk);
        start_w[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (!done_w[d] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done_reached_dut%0d", d), 64'(done_w[d]), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input int d, input string tag);
        check({tag, "_dut_rst"}, 64'(dut_rst_w[d]), 64'd1);
        check({tag, "_busy"},    64'(busy_w[d]),    64'd0);
        check({tag, "_done"},    64'(done_w[d]),    64'd0);
        check({tag, "_pass"},    64'(pass_w[d]),    64'd0);
        check({tag, "_sig"},     64'(sig_w[d]),     64'hFFFF_FFFF);
        check({tag, "_pulse"},   64'(pulse_w[d]),   64'd0);
        check({tag, "_stall"},   64'(stall_w[d]),   64'd0);
    endtask

    // Monitor: measures windows and compares against the scoreboard when done rises.
    int   busy_len [2];
    int   hold_run [2];
    int   n_holds  [2];
    int   hold_obs [2][8];
    logic done_prev[2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            busy_len[d] = 0; hold_run[d] = 0; n_holds[d] = 0; done_prev[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done_w[d] && !done_prev[d]) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    chk++;
                    err++;
                    $display("FAIL unexpected_done dut%0d actual=1 required=0", d);
                end else begin
                    exp_t e;
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("sig_dut%0d", d),      64'(sig_w[d]),   64'(e.sig));
                    check($sformatf("pass_dut%0d", d),     64'(pass_w[d]),  64'(e.pass));
                    check($sformatf("pulse_dut%0d", d),    64'(pulse_w[d]), 64'(e.pulse));
                    check($sformatf("stall_dut%0d", d),    64'(stall_w[d]), 64'd0);
                    check($sformatf("dut_rst_done_dut%0d", d), 64'(dut_rst_w[d]), 64'd0);
                    check($sformatf("busy_len_dut%0d", d), 64'(busy_len[d]), 64'(e.busy_len));
                    check($sformatf("n_holds_dut%0d", d),  64'(n_holds[d]),  64'(e.n_holds));
                    for (int i = 0; i < e.n_holds && i < 4; i++) begin
                        check($sformatf("hold%0d_dut%0d", i, d),
                              64'(hold_obs[d][i]), 64'(e.holds[i]));
                    end
                end
                busy_len[d] = 0; hold_run[d] = 0; n_holds[d] = 0;
            end else if (busy_w[d]) begin
                busy_len[d]++;
                if (dut_rst_w[d]) begin
                    hold_run[d]++;
                end else if (hold_run[d] != 0) begin
                    if (n_holds[d] < 8) hold_obs[d][n_holds[d]] = hold_run[d];
                    n_holds[d]++;
                    hold_run[d] = 0;
                end
            end else begin
                busy_len[d] = 0; hold_run[d] = 0; n_holds[d] = 0;
            end
            done_prev[d] = done_w[d];
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          p;
        logic [31:0] m0;
        logic [31:0] mp;

        for (int d = 0; d < 2; d++) begin
            start_w[d] = 1'b0; abort_w[d] = 1'b0; expect_w[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check_reset_vals(0, "reset0");
        check("reset_dut_rst_dut1", 64'(dut_rst_w[1]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("idle_dut_rst", 64'(dut_rst_w[0]), 64'd1);

        // All-zero observation, golden matches
        m0 = model(1'b0, 0);
        expect_w[0] = m0;
        push_exp(0, m0, 1'b1, 2, 1, 121);
        do_start(0, p);
        wait_done(0);
        repeat (4) @(negedge clk);
        check("pass_held_in_done", 64'(pass_w[0]), 64'd1);
        check("done_held",         64'(done_w[0]), 64'd1);

        // Restart from DONE with a wrong golden
        expect_w[0] = m0 ^ 32'd1;
        push_exp(0, m0, 1'b0, 2, 1, 121);
        do_start(0, p);
        check("restart_pulse", 64'(pulse_w[0]), 64'd1);
        wait_done(0);

        // Varying observation; a stray start inside FINAL must be ignored
        obs_mode = 1'b1;
        do_start(0, p);
        mp = model(1'b1, p);
        expect_w[0] = mp;
        push_exp(0, mp, 1'b1, 2, 1, 121);
        repeat (40) @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        wait_done(0);

        // Abort together with start in the third RUN cycle
        do_start(0, p);
        repeat (12) @(negedge clk);
        check("pre_abort_in_run", 64'(dut_rst_w[0]), 64'd0);
        abort_w[0] = 1'b1;
        start_w[0] = 1'b1;
        @(negedge clk);
        abort_w[0] = 1'b0;
        start_w[0] = 1'b0;
        check("abort_dut_rst", 64'(dut_rst_w[0]), 64'd1);
        check("abort_pulse",   64'(pulse_w[0]),   64'd0);
        check("abort_busy",    64'(busy_w[0]),    64'd0);
        check("abort_done",    64'(done_w[0]),    64'd0);
        repeat (20) @(negedge clk);
        check("abort_no_restart", 64'(busy_w[0]), 64'd0);

        // Asynchronous reset in the middle of FINAL, then an uninterrupted rerun
        do_start(0, p);
        repeat (60) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals(0, "midrst");
        @(negedge clk);
        rst = 1'b1;
        do_start(0, p);
        mp = model(1'b1, p);
        expect_w[0] = mp;
        push_exp(0, mp, 1'b1, 2, 1, 121);
        wait_done(0);

        // Four-pulse variant with three-cycle later pulses
        obs_mode = 1'b0;
        expect_w[1] = m0;
        push_exp(1, m0, 1'b1, 4, 3, 149);
        do_start(1, p);
        wait_done(1);

        repeat (3) @(negedge clk);
        check("scoreboard0_empty", 64'(q0.size()), 64'd0);
        check("scoreboard1_empty", 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
